// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking, active-area coordinates and line/frame start pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hs,
  output logic          vs,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL < 2 || V_TOTAL < 2) begin : g_param_check
    $error("vga_timing_gen: invalid timing parameters");
  end

  localparam logic          HS_ON  = (HS_POL != 0);
  localparam logic          VS_ON  = (VS_POL != 0);
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SS   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SS   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SE   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] hc_q, hc_d;
  logic [YW-1:0] vc_q, vc_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic in_video, in_hsync, in_vsync;

  assign in_video = (hc_q < H_ACT) && (vc_q < V_ACT);
  assign in_hsync = (hc_q >= H_SS) && (hc_q < H_SE);
  assign in_vsync = (vc_q >= V_SS) && (vc_q < V_SE);

  // Outputs decode the counter state of the same pix_en cycle; pulses drop
  // to zero on any cycle without pix_en, everything else holds.
  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    x_d           = x_q;
    y_d           = y_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
      video_on_d    = in_video;
      x_d           = in_video ? hc_q : '0;
      y_d           = in_video ? vc_q : '0;
      hs_d          = in_hsync ? HS_ON : ~HS_ON;
      vs_d          = in_vsync ? VS_ON : ~VS_ON;
      line_start_d  = (hc_q == '0);
      frame_start_d = (hc_q == '0) && (vc_q == '0);
      if (frame_start_d) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q          <= '0;
      vc_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= ~HS_ON;
      vs_q          <= ~VS_ON;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, default 96, horizontal sync width (pixels).
REQ-004 Parameter H_BP, default 48, horizontal back porch (pixels).
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, default 2, vertical sync width (lines).
REQ-008 Parameter V_BP, default 33, vertical back porch (lines).
REQ-009 Parameter HS_POL, default 0, hs asserted level (0 = active-low).
REQ-010 Parameter VS_POL, default 0, vs asserted level (0 = active-low).
REQ-011 Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = clog2(H_TOTAL), YW = clog2(V_TOTAL).
REQ-012 clk  input  1  single clock; all state changes on its rising edge.
REQ-013 rst  input  1  synchronous, active-high reset.
REQ-014 pix_en  input  1  pixel clock enable; counters and outputs advance only when high.
REQ-015 x  output  XW  active-area column, registered.
REQ-016 y  output  YW  active-area row, registered.
REQ-017 hs  output  1  horizontal sync, polarity per HS_POL, registered.
REQ-018 vs  output  1  vertical sync, polarity per VS_POL, registered.
REQ-019 video_on  output  1  high while in active area, registered.
REQ-020 line_start  output  1  one-clk pulse at first pixel of every line.
REQ-021 frame_start  output  1  one-clk pulse at first pixel of every frame.
REQ-022 frame_count  output  16  frames started since reset, wraps 65535 -> 0.

Function
REQ-023 Internal hc (XW bits) SHALL increment on each pix_en cycle, wrapping H_TOTAL-1 -> 0.
REQ-024 Internal vc (YW bits) SHALL increment on the pix_en cycle where hc wraps, wrapping V_TOTAL-1 -> 0; unchanged otherwise.
REQ-025 Line order SHALL be active, front porch, sync, back porch (same vertically); active region starts at hc=0, vc=0.
REQ-026 Registered outputs SHALL load only on pix_en cycles, from the decode of hc/vc in that cycle (latency one clk after the counter state); held when pix_en=0.
REQ-027 video_on SHALL be (hc < H_ACTIVE) && (vc < V_ACTIVE).
REQ-028 x/y SHALL equal hc/vc when video_on, else 0.
REQ-029 hs SHALL equal HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; vs likewise on vc with V_* parameters, independent of hc.
REQ-030 line_start SHALL be 1 for exactly one clk after a pix_en cycle with hc=0, and 0 in every clk following a pix_en=0 cycle.
REQ-031 frame_start SHALL follow the REQ-030 rule with hc=0 && vc=0; it coincides with a line_start pulse.
REQ-032 frame_count SHALL increment in the same clk that frame_start is asserted.
REQ-033 Any zero or negative porch/sync parameter, or H_TOTAL/V_TOTAL < 2, SHALL be rejected at elaboration.

Reset
REQ-034 On rst: hc=0, vc=0, x=0, y=0, video_on=0, line_start=0, frame_start=0, frame_count=0, hs=~HS_POL, vs=~VS_POL.
REQ-035 rst SHALL override pix_en; asserted mid-line/mid-frame, restart is from (0,0) with no partial pulses.
REQ-036 The first pix_en cycle after rst release SHALL produce frame_start=1, line_start=1, frame_count=1, video_on=1, x=0, y=0 one clk later.

Verification
REQ-037 Defaults, pix_en=1: hs low for exactly 96 clks per 800-clk line, falling edge 656 clks after line_start; video_on high 640 clks per line.
REQ-038 Defaults, pix_en=1: vs low for 2 lines (1600 clks) starting 490 lines after frame_start; frame_start period 420000 clks.
REQ-039 pix_en toggling 1/0 (divide-by-2): all timings in REQ-037/038 double; pulses stay one clk wide; outputs stable on pix_en=0 cycles.
REQ-040 HS_POL=1, VS_POL=1: sync outputs inverted; reset values hs=0, vs=0.
REQ-041 rst asserted at hc=300, vc=200 for one clk: next outputs match REQ-034; first pix_en after release gives frame_start, frame_count=1.
REQ-042 Small params (H 4/1/1/1, V 3/1/1/1), 65536+ frames: frame_count wraps 65535 -> 0; x in 0..3, y in 0..2 only when video_on.
